// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control encodings, default widths and the
// control bundle used for pipeline bubbles.
package cpu_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned RW_DEFAULT = 5;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic    valid;
        logic    regwrite;
        logic    memread;
        logic    alusrc;
        alu_op_t aluop;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{
        valid:    1'b0,
        regwrite: 1'b0,
        memread:  1'b0,
        alusrc:   1'b0,
        aluop:    ALU_ADD
    };

endpackage

// File: rtl/fwd_mux.sv
// One operand forwarding select: EX/MEM beats MEM/WB beats the stored
// register-file value; register 0 is never forwarded.
module fwd_mux #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] data
);

    always_comb begin
        data = reg_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idx)) begin
            data = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idx)) begin
            data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, immediate
// select, load-use hazard detection, stall hold and flush bubbles.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic          id_alusrc,
    input  logic [1:0]    id_aluop,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          exmem_regwrite,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic [DW-1:0] memwb_result,
    input  logic          stall,
    input  logic          flush,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [1:0]    CTRL,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic [RW-1:0] ex_rd,
    output logic [DW-1:0] ex_rt_fwd,
    output logic          load_use
);

    ex_ctrl_t      ctrl_q;
    logic [RW-1:0] rs_q, rt_q, rd_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [DW-1:0] rs_fwd, rt_fwd;

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx            (rs_q),
        .reg_data       (rs_data_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .data           (rs_fwd)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx            (rt_q),
        .reg_data       (rt_data_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .data           (rt_fwd)
    );

    always_comb begin
        load_use = 1'b0;
        if (!stall && !flush) begin
            load_use = ctrl_q.valid && ctrl_q.memread && (rd_q != '0) && id_valid &&
                       ((id_rs == rd_q) || (id_rt == rd_q));
        end
    end

    // load_use is already masked by stall/flush, so it only bubbles when neither is set.
    always_ff @(posedge clk) begin
        if (reset || flush || load_use) begin
            ctrl_q    <= BUBBLE_CTRL;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (stall) begin
            // Refresh operands so a producer retiring mid-stall is not lost.
            rs_data_q <= rs_fwd;
            rt_data_q <= rt_fwd;
        end else begin
            ctrl_q.valid    <= id_valid;
            ctrl_q.regwrite <= id_regwrite;
            ctrl_q.memread  <= id_memread;
            ctrl_q.alusrc   <= id_alusrc;
            ctrl_q.aluop    <= alu_op_t'(id_aluop);
            rs_q            <= id_rs;
            rt_q            <= id_rt;
            rd_q            <= id_rd;
            rs_data_q       <= id_rs_data;
            rt_data_q       <= id_rt_data;
            imm_q           <= {{(DW-16){id_imm[15]}}, id_imm};
        end
    end

    assign A           = rs_fwd;
    assign B           = ctrl_q.alusrc ? imm_q : rt_fwd;
    assign ex_rt_fwd   = rt_fwd;
    assign CTRL        = ctrl_q.aluop;
    assign ex_valid    = ctrl_q.valid;
    assign ex_regwrite = ctrl_q.valid & ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.valid & ctrl_q.memread;
    assign ex_rd       = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the stage contents.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, id_alusrc, id_regwrite, id_memread;
    logic [31:0] id_rs_data, id_rt_data, exmem_result, memwb_result;
    logic [15:0] id_imm;
    logic [1:0]  id_aluop;
    logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
    logic        exmem_regwrite, memwb_regwrite, stall, flush;
    logic [31:0] A, B, ex_rt_fwd;
    logic [1:0]  CTRL;
    logic        ex_valid, ex_regwrite, ex_memread, load_use;
    logic [4:0]  ex_rd;

    int total = 0;
    int bad   = 0;

    // Model of what the stage should hold.
    logic        m_valid, m_rw, m_mr, m_src;
    logic [1:0]  m_op;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rsd, m_rtd, m_imm;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .stall(stall), .flush(flush),
        .A(A), .B(B), .CTRL(CTRL), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_rt_fwd(ex_rt_fwd), .load_use(load_use)
    );

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
        return v;
    endfunction

    function automatic logic model_load_use();
        if (stall || flush) return 1'b0;
        return m_valid && m_mr && m_rd != 0 && id_valid && (id_rs == m_rd || id_rt == m_rd);
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        logic        lu;
        logic [31:0] frs, frt;
        lu  = model_load_use();
        frs = fwd(m_rs, m_rsd);
        frt = fwd(m_rt, m_rtd);
        @(posedge clk);
        if (reset || flush || lu) begin
            {m_valid, m_rw, m_mr, m_src, m_op} = '0;
            {m_rs, m_rt, m_rd} = '0;
            {m_rsd, m_rtd, m_imm} = '0;
        end else if (stall) begin
            m_rsd = frs;
            m_rtd = frt;
        end else begin
            m_valid = id_valid;    m_rw = id_regwrite; m_mr = id_memread;
            m_src   = id_alusrc;   m_op = id_aluop;
            m_rs    = id_rs;       m_rt = id_rt;       m_rd = id_rd;
            m_rsd   = id_rs_data;  m_rtd = id_rt_data;
            m_imm   = 32'($signed(id_imm));
        end
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; id_valid = 0; id_alusrc = 0; id_regwrite = 0; id_memread = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_aluop = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_result = 0; memwb_result = 0; stall = 0; flush = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; id_valid = 1; id_rs = 3; id_rs_data = 32'hDEAD; id_aluop = 3;
        tick();
        total++;
        if ({A, B, CTRL, ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rt_fwd, load_use} !== '0) begin
            bad++;
            $display("FAIL reset_outputs A=%h B=%h CTRL=%b valid=%b rd=%0d rtf=%h lu=%b expected all zero",
                     A, B, CTRL, ex_valid, ex_rd, ex_rt_fwd, load_use);
        end
        clear_inputs();
    endtask

    task automatic test_capture();
        clear_inputs();
        id_valid = 1; id_rs = 5; id_rt = 6; id_rs_data = 32'h10; id_rt_data = 32'h20;
        id_aluop = 2'b01; id_rd = 9; id_regwrite = 1;
        tick();
        total++;
        if ({A, B, CTRL, ex_valid} !== {32'h10, 32'h20, 2'b01, 1'b1}) begin
            bad++;
            $display("FAIL capture A=%h B=%h CTRL=%b valid=%b expected 10/20/01/1", A, B, CTRL, ex_valid);
        end
    endtask

    task automatic test_double_fwd();
        exmem_regwrite = 1; memwb_regwrite = 1; exmem_rd = 5; memwb_rd = 5;
        exmem_result = 32'hAAAA; memwb_result = 32'hBBBB;
        #1;
        total++;
        if (A !== 32'hAAAA) begin bad++; $display("FAIL double_fwd A=%h expected 0000aaaa", A); end
        memwb_rd = 0; exmem_rd = 0;
        #1;
        total++;
        if (A !== 32'h10) begin bad++; $display("FAIL rd0_no_fwd A=%h expected 00000010", A); end
        memwb_rd = 5;
        #1;
        total++;
        if (A !== 32'hBBBB) begin bad++; $display("FAIL memwb_fwd A=%h expected 0000bbbb", A); end
        clear_inputs();
    endtask

    task automatic test_imm();
        clear_inputs();
        id_valid = 1; id_rt = 6; id_rt_data = 32'h20; id_imm = 16'hFFFC; id_alusrc = 1;
        tick();
        exmem_regwrite = 1; exmem_rd = 6; exmem_result = 32'h77;
        #1;
        total++;
        if (B !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_B B=%h expected fffffffc", B); end
        total++;
        if (ex_rt_fwd !== 32'h77) begin bad++; $display("FAIL imm_rt_fwd got=%h expected 00000077", ex_rt_fwd); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd = 7;
        tick();
        clear_inputs();
        id_valid = 1; id_rs = 7; id_rt = 2; id_rs_data = 32'h99; id_aluop = 2'b11; id_rd = 8;
        #1;
        total++;
        if (load_use !== 1'b1) begin bad++; $display("FAIL load_use_detect got=%b expected 1", load_use); end
        tick();
        total++;
        if ({ex_valid, CTRL, load_use} !== 4'b0) begin
            bad++;
            $display("FAIL load_use_bubble valid=%b CTRL=%b lu=%b expected 0/00/0", ex_valid, CTRL, load_use);
        end
        tick();
        total++;
        if ({ex_valid, CTRL, A, ex_rd} !== {1'b1, 2'b11, 32'h99, 5'd8}) begin
            bad++;
            $display("FAIL load_use_release valid=%b CTRL=%b A=%h rd=%0d expected 1/11/99/8", ex_valid, CTRL, A, ex_rd);
        end
    endtask

    task automatic test_stall_refresh();
        clear_inputs();
        id_valid = 1; id_rs = 3; id_rs_data = 32'h5; id_rt = 4; id_rt_data = 32'h6; id_rd = 10;
        tick();
        id_rs_data = 32'hDEAD; id_rd = 12;
        stall = 1; memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'h1234;
        #1;
        total++;
        if (A !== 32'h1234) begin bad++; $display("FAIL stall_fwd A=%h expected 00001234", A); end
        tick();
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
        tick();
        tick();
        stall = 0;
        #1;
        total++;
        if ({A, ex_rd, ex_valid} !== {32'h1234, 5'd10, 1'b1}) begin
            bad++;
            $display("FAIL stall_refresh A=%h rd=%0d valid=%b expected 1234/10/1", A, ex_rd, ex_valid);
        end
        clear_inputs();
    endtask

    task automatic test_flush_stall();
        clear_inputs();
        id_valid = 1; id_memread = 1; id_rd = 7; id_rs_data = 32'h55; id_rs = 1;
        tick();
        clear_inputs();
        id_valid = 1; id_rs = 7; stall = 1;
        #1;
        total++;
        if (load_use !== 1'b0) begin bad++; $display("FAIL lu_masked_by_stall got=%b expected 0", load_use); end
        flush = 1;
        tick();
        total++;
        if ({ex_valid, CTRL, A, ex_rd, ex_memread} !== '0) begin
            bad++;
            $display("FAIL flush_stall valid=%b CTRL=%b A=%h rd=%0d mr=%b expected zero", ex_valid, CTRL, A, ex_rd, ex_memread);
        end
        clear_inputs();
    endtask

    task automatic test_reset_flush();
        clear_inputs();
        id_valid = 1; id_rs = 2; id_rs_data = 32'hCAFE; id_rt_data = 32'hBEEF; id_rt = 3;
        id_aluop = 2'b10; id_regwrite = 1; id_rd = 4;
        tick();
        reset = 1; flush = 1;
        tick();
        total++;
        if ({A, B, CTRL, ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rt_fwd, load_use} !== '0) begin
            bad++;
            $display("FAIL reset_flush A=%h B=%h CTRL=%b valid=%b rd=%0d expected zero", A, B, CTRL, ex_valid, ex_rd);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [31:0] ea, eb, ert;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            id_valid = $urandom_range(0, 3) != 0;
            id_memread = ($urandom_range(0, 2) == 0);
            id_regwrite = $urandom_range(0, 1);
            id_alusrc = $urandom_range(0, 1);
            id_aluop = 2'($urandom_range(0, 3));
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
            exmem_regwrite = $urandom_range(0, 1); memwb_regwrite = $urandom_range(0, 1);
            exmem_rd = 5'($urandom_range(0, 7)); memwb_rd = 5'($urandom_range(0, 7));
            exmem_result = $urandom; memwb_result = $urandom;
            #1;
            ea  = fwd(m_rs, m_rsd);
            ert = fwd(m_rt, m_rtd);
            eb  = m_src ? m_imm : ert;
            total++;
            if (A !== ea) begin bad++; $display("FAIL rand_A it=%0d got=%h expected=%h", i, A, ea); end
            total++;
            if (B !== eb) begin bad++; $display("FAIL rand_B it=%0d got=%h expected=%h", i, B, eb); end
            total++;
            if (ex_rt_fwd !== ert) begin bad++; $display("FAIL rand_rt_fwd it=%0d got=%h expected=%h", i, ex_rt_fwd, ert); end
            total++;
            if ({CTRL, ex_valid, ex_regwrite, ex_memread, ex_rd} !==
                {m_op, m_valid, m_valid & m_rw, m_valid & m_mr, m_rd}) begin
                bad++;
                $display("FAIL rand_ctrl it=%0d got=%b/%b%b%b/%0d expected=%b/%b%b%b/%0d", i,
                         CTRL, ex_valid, ex_regwrite, ex_memread, ex_rd,
                         m_op, m_valid, m_valid & m_rw, m_valid & m_mr, m_rd);
            end
            total++;
            if (load_use !== model_load_use()) begin
                bad++;
                $display("FAIL rand_load_use it=%0d got=%b expected=%b", i, load_use, model_load_use());
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        {m_valid, m_rw, m_mr, m_src, m_op, m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm} = '0;
        #2;
        test_reset();
        test_capture();
        test_double_fwd();
        test_imm();
        test_load_use();
        test_stall_refresh();
        test_flush_stall();
        test_reset_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
